// File: rtl/opto_pkg.sv
// Shared definitions for the optical code-wheel edge decoder.
//   state_t      : decoder synchronisation states
//   PER_W        : width of the tooth-to-tooth period counter
//   REV_W        : width of the revolution period counter / o_rev_period
//   CNT_W        : width of the per-revolution fall counter
//   TEETH_DEF    : default falls per revolution, zero edge included
//   FILT_LEN_DEF : default glitch-filter run length
package opto_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC     = 2'd0,
        ST_ONE_PERIOD = 2'd1,
        ST_LOCKED     = 2'd2
    } state_t;

    localparam int PER_W        = 20;
    localparam int REV_W        = 24;
    localparam int CNT_W        = 8;
    localparam int TEETH_DEF    = 40;
    localparam int FILT_LEN_DEF = 4;

endpackage

// File: rtl/opto_edge_decoder_if.sv
// Signal bundle around one opto_edge_decoder instance.
//   master : decoder side (consumes opto_raw, produces the event outputs)
//   slave  : environment side (drives opto_raw, observes the events)
interface opto_edge_decoder_if;
    import opto_pkg::*;

    logic             opto_raw;
    logic             opto_fall;
    logic             zero_sign;
    logic [CNT_W-1:0] fall_cnt;
    logic             locked;
    logic             tooth_err;
    logic [REV_W-1:0] rev_period;
    logic             rev_valid;

    modport master (
        input  opto_raw,
        output opto_fall, zero_sign, fall_cnt, locked, tooth_err, rev_period, rev_valid
    );

    modport slave (
        output opto_raw,
        input  opto_fall, zero_sign, fall_cnt, locked, tooth_err, rev_period, rev_valid
    );
endinterface

// File: rtl/opto_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// The filtered level only follows the synchronized input after FILT_LEN
// consecutive samples that differ from it; fall pulses for one cycle on
// each accepted 1->0 change (2+FILT_LEN cycles after the raw edge).
//   clk  : clock
//   rst  : synchronous active-high reset (everything idles high)
//   raw  : asynchronous photo-interrupter level
//   fall : one-cycle pulse on an accepted falling level change
module opto_glitch_filter
    import opto_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic fall
);
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_p2;
    logic [RUN_W-1:0] run_cnt;
    logic             accept;

    // run_cnt counts earlier differing samples, so the FILT_LEN-th one accepts
    assign accept = (sync_p1 != level_p2) && (run_cnt == RUN_W'(FILT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            level_p2 <= 1'b1;
            run_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            // stage p0/p1: metastability synchronizer
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // stage p2: filtered level and fall pulse
            fall    <= accept && !sync_p1;
            if (sync_p1 == level_p2) begin
                run_cnt <= '0;
            end else if (accept) begin
                level_p2 <= sync_p1;
                run_cnt  <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/opto_edge_decoder.sv
// Code-wheel decoder: filters the opto input, measures tooth periods,
// finds the wide (zero) slot by 2*P > 3*Q and tracks revolutions.
//   i_clk_50m    : clock
//   i_rst        : synchronous active-high reset
//   i_opto_raw   : asynchronous photo-interrupter level
//   o_opto_fall  : pulse per accepted non-zero tooth fall (LOCKED only)
//   o_zero_sign  : pulse on the fall ending the wide slot
//   o_fall_cnt   : non-zero falls since the last zero (saturating)
//   o_locked     : high while in LOCKED
//   o_tooth_err  : pulse with o_zero_sign when the tooth count is wrong
//   o_rev_period : cycles in the last complete revolution
//   o_rev_valid  : pulse when o_rev_period updates
module opto_edge_decoder
    import opto_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter int TEETH    = TEETH_DEF,
    parameter int PERIOD_W = PER_W
) (
    input  logic             i_clk_50m,
    input  logic             i_rst,
    input  logic             i_opto_raw,
    output logic             o_opto_fall,
    output logic             o_zero_sign,
    output logic [CNT_W-1:0] o_fall_cnt,
    output logic             o_locked,
    output logic             o_tooth_err,
    output logic [REV_W-1:0] o_rev_period,
    output logic             o_rev_valid
);
    localparam int                  CMP_W    = PERIOD_W + 2;
    localparam logic [PERIOD_W-1:0] PER_MAX  = '1;
    localparam logic [CNT_W-1:0]    TEETH_NZ = CNT_W'(TEETH - 1);

    function automatic logic [PERIOD_W-1:0] per_inc(input logic [PERIOD_W-1:0] v);
        return (v == PER_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [REV_W-1:0] rev_inc(input logic [REV_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Q == 0 means no previous period has been captured yet: never a zero.
    function automatic logic is_zero(input logic [PERIOD_W-1:0] p,
                                     input logic [PERIOD_W-1:0] q);
        logic [CMP_W-1:0] p2;
        logic [CMP_W-1:0] q3;
        p2 = {1'b0, p, 1'b0};
        q3 = {2'b00, q} + {1'b0, q, 1'b0};
        return (q != '0) && (p2 > q3);
    endfunction

    logic                fall_p0;
    state_t              state;
    state_t              state_nx;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W-1:0] per_q;
    logic [PERIOD_W-1:0] q_nx;
    logic [REV_W-1:0]    rev_cnt;
    logic                sat;
    logic                zero_hit;
    logic                fall_nx;
    logic                zero_nx;
    logic                err_nx;
    logic                revv_nx;
    logic                rev_restart;

    opto_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk  (i_clk_50m),
        .rst  (i_rst),
        .raw  (i_opto_raw),
        .fall (fall_p0)
    );

    assign sat      = (per_cnt == PER_MAX);
    assign zero_hit = is_zero(per_cnt, per_q);

    always_comb begin
        state_nx    = state;
        q_nx        = per_q;
        fall_nx     = 1'b0;
        zero_nx     = 1'b0;
        err_nx      = 1'b0;
        revv_nx     = 1'b0;
        rev_restart = 1'b0;
        if (sat) begin
            // a stalled wheel drops sync; a coincident fall starts a new search
            q_nx     = '0;
            state_nx = fall_p0 ? ST_ONE_PERIOD : ST_UNSYNC;
        end else if (fall_p0) begin
            unique case (state)
                ST_UNSYNC: begin
                    state_nx = ST_ONE_PERIOD;
                end
                ST_ONE_PERIOD: begin
                    q_nx = per_cnt;
                    if (zero_hit) begin
                        state_nx    = ST_LOCKED;
                        zero_nx     = 1'b1;
                        rev_restart = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    q_nx = per_cnt;
                    if (zero_hit) begin
                        zero_nx     = 1'b1;
                        err_nx      = (o_fall_cnt != TEETH_NZ);
                        revv_nx     = 1'b1;
                        rev_restart = 1'b1;
                    end else begin
                        fall_nx = 1'b1;
                    end
                end
                default: state_nx = ST_UNSYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state        <= ST_UNSYNC;
            per_cnt      <= '0;
            per_q        <= '0;
            rev_cnt      <= '0;
            o_opto_fall  <= 1'b0;
            o_zero_sign  <= 1'b0;
            o_tooth_err  <= 1'b0;
            o_rev_valid  <= 1'b0;
            o_locked     <= 1'b0;
            o_fall_cnt   <= '0;
            o_rev_period <= '0;
        end else begin
            // stage p1: decision registers and event outputs
            state       <= state_nx;
            per_cnt     <= fall_p0 ? PERIOD_W'(1) : per_inc(per_cnt);
            per_q       <= q_nx;
            rev_cnt     <= rev_restart ? REV_W'(1) : rev_inc(rev_cnt);
            o_opto_fall <= fall_nx;
            o_zero_sign <= zero_nx;
            o_tooth_err <= err_nx;
            o_rev_valid <= revv_nx;
            o_locked    <= (state_nx == ST_LOCKED);
            if (revv_nx) begin
                o_rev_period <= rev_cnt;
            end
            // stage p2: counter follows the pulses, so it still shows the
            // revolution's count during the o_zero_sign cycle
            if (o_zero_sign) begin
                o_fall_cnt <= '0;
            end else if (o_opto_fall) begin
                o_fall_cnt <= cnt_inc(o_fall_cnt);
            end
        end
    end
endmodule
